// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: one FSM steps each instruction through
// fetch/decode/execute/memory/writeback and drives datapath strobes per state.
module multicycle_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic [3:0] state,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_source,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       memto_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       instr_done,
   output logic       illegal_op
);

   localparam int unsigned OP_W = 6;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   localparam logic [1:0] PCSRC_ALU   = 2'b00;
   localparam logic [1:0] PCSRC_OUT   = 2'b01;
   localparam logic [1:0] PCSRC_JUMP  = 2'b10;
   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_SHIMM  = 2'b11;
   localparam logic [1:0] ALU_ADD     = 2'b00;
   localparam logic [1:0] ALU_SUB     = 2'b01;
   localparam logic [1:0] ALU_FUNCT   = 2'b10;

   typedef enum logic [3:0] {
      S_RESET    = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_R_EXEC   = 4'd7,
      S_R_WB     = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10
   } state_t;

   state_t state_q;
   state_t state_d;

   // State register; reset is synchronous so it can abandon a stalled access.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = 4'(state_q);

   // Next state and per-state datapath strobes.
   always_comb begin
      state_d       = state_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = PCSRC_ALU;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      memto_reg     = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      alu_op        = ALU_ADD;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;

      case (state_q)
         S_RESET: begin
            state_d = S_FETCH;
         end

         // PC+4 computed on the shared ALU while the instruction is read.
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            state_d   = mem_ready ? S_DECODE : S_FETCH;
         end

         // Branch target computed speculatively into ALUOut.
         S_DECODE: begin
            alu_src_b = SRCB_SHIMM;
            case (opcode)
               OP_RTYPE:     state_d = S_R_EXEC;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               default: begin
                  illegal_op = 1'b1;
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end

         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end

         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            state_d  = mem_ready ? S_MEM_WB : S_MEM_RD;
         end

         S_MEM_WB: begin
            memto_reg  = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end

         S_MEM_WR: begin
            mem_write  = 1'b1;
            iord       = 1'b1;
            instr_done = mem_ready;
            state_d    = mem_ready ? S_FETCH : S_MEM_WR;
         end

         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
            state_d   = S_R_WB;
         end

         S_R_WB: begin
            reg_dst    = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end

         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_OUT;
            instr_done    = 1'b1;
            state_d       = S_FETCH;
         end

         S_JUMP: begin
            pc_write   = 1'b1;
            pc_source  = PCSRC_JUMP;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end

         default: begin
            state_d = S_RESET;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle stimulus queued with the
// expected state and strobes, compared on the falling edge.
module tb_multicycle_control;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic [3:0] state;
   logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic       memto_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
   logic [1:0] pc_source, alu_src_b, alu_op;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       memto_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       instr_done;
      logic       illegal_op;
   } out_t;

   typedef struct {
      bit         rst;
      bit         mr;
      logic [5:0] op;
      logic [3:0] st;
   } stim_t;

   typedef struct {
      logic [3:0] st;
      out_t       o;
   } exp_t;

   stim_t stim_q[$];
   exp_t  sb_q[$];
   int    n_checks;
   int    n_errors;
   int    done_seen;
   int    done_exp;
   int    illegal_seen;
   int    illegal_exp;
   out_t  act;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .state(state), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .pc_source(pc_source), .iord(iord), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .memto_reg(memto_reg),
      .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
      .illegal_op(illegal_op)
   );

   assign act = '{pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
                  ir_write, memto_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                  alu_op, instr_done, illegal_op};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected strobes written directly from the per-state output table.
   function automatic out_t model(input logic [3:0] st, input bit mr, input logic [5:0] op);
      out_t o;
      o = '0;
      case (st)
         4'd1: begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
         4'd2: begin
            o.alu_src_b = 2'b11;
            if (!(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010})) begin
               o.illegal_op = 1; o.instr_done = 1;
            end
         end
         4'd3:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
         4'd4:  begin o.mem_read = 1; o.iord = 1; end
         4'd5:  begin o.memto_reg = 1; o.reg_write = 1; o.instr_done = 1; end
         4'd6:  begin o.mem_write = 1; o.iord = 1; o.instr_done = mr; end
         4'd7:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
         4'd8:  begin o.reg_dst = 1; o.reg_write = 1; o.instr_done = 1; end
         4'd9:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1;
                      o.pc_source = 2'b01; o.instr_done = 1; end
         4'd10: begin o.pc_write = 1; o.pc_source = 2'b10; o.instr_done = 1; end
         default: o = '0;
      endcase
      return o;
   endfunction

   function automatic bit rnd();
      return 1'($urandom_range(1, 0));
   endfunction

   task automatic add(input bit r, input bit m, input logic [5:0] op, input logic [3:0] st);
      stim_t s;
      s.rst = r; s.mr = m; s.op = op; s.st = st;
      stim_q.push_back(s);
   endtask

   // Queue one instruction: fw fetch stalls, mw data stalls, optional reset while stalled in MEM_WR.
   task automatic add_instr(input logic [5:0] op, input int fw, input int mw, input bit abort);
      for (int i = 0; i < fw; i++) add(1, 0, op, 4'd1);
      add(1, 1, op, 4'd1);
      add(1, rnd(), op, 4'd2);
      case (op)
         6'b000000: begin add(1, rnd(), op, 4'd7); add(1, rnd(), op, 4'd8); end
         6'b100011: begin
            add(1, rnd(), op, 4'd3);
            for (int i = 0; i < mw; i++) add(1, 0, op, 4'd4);
            add(1, 1, op, 4'd4);
            add(1, rnd(), op, 4'd5);
         end
         6'b101011: begin
            add(1, rnd(), op, 4'd3);
            if (abort) begin
               add(0, 0, op, 4'd6);
               add(1, rnd(), op, 4'd0);
               return;
            end
            for (int i = 0; i < mw; i++) add(1, 0, op, 4'd6);
            add(1, 1, op, 4'd6);
         end
         6'b000100: add(1, rnd(), op, 4'd9);
         6'b000010: add(1, rnd(), op, 4'd10);
         default: illegal_exp++;
      endcase
      done_exp++;
   endtask

   initial begin
      stim_t s;
      exp_t  e;
      rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'b0;
      n_checks = 0; n_errors = 0; done_seen = 0; done_exp = 0;
      illegal_seen = 0; illegal_exp = 0;

      add(0, 0, 6'b0, 4'd0);
      add(0, 1, 6'b0, 4'd0);
      add(1, 0, 6'b0, 4'd0);
      add_instr(6'b000000, 1, 0, 0);
      add_instr(6'b000000, 0, 0, 0);
      add_instr(6'b100011, 0, 2, 0);
      add_instr(6'b101011, 0, 0, 0);
      add_instr(6'b000100, 0, 0, 0);
      add_instr(6'b000010, 0, 0, 0);
      add_instr(6'b111111, 0, 0, 0);
      add_instr(6'b001000, 2, 0, 0);
      add_instr(6'b100011, 2, 0, 0);
      add_instr(6'b101011, 1, 3, 0);
      add_instr(6'b101011, 0, 0, 1);
      add_instr(6'b000000, 0, 0, 0);
      add_instr(6'b000100, 3, 0, 0);

      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         @(posedge clk);
         #1;
         rst_n = s.rst; mem_ready = s.mr; opcode = s.op;
         e.st = s.st;
         e.o  = model(s.st, s.mr, s.op);
         sb_q.push_back(e);
         @(negedge clk);
         e = sb_q.pop_front();
         check("state", 32'(state), 32'(e.st));
         check("outputs", 32'(act), 32'(e.o));
         check("exclusive", 32'({mem_read & mem_write, reg_write & mem_write}), 32'd0);
         if (instr_done) done_seen++;
         if (illegal_op) illegal_seen++;
      end

      check("instr_done_count", 32'(done_seen), 32'(done_exp));
      check("illegal_count", 32'(illegal_seen), 32'(illegal_exp));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
